seg_timer_display: RTL and testbench

SEG_TIMER_DISPLAY -- requirements
Module: seg_timer_display

---
 rtl/seg_pkg.sv | 70 +++++++
 rtl/seg_decoder.sv | 23 ++
 rtl/seg_timer_display.sv | 137 +++++++++++++
 tb/tb_seg_timer_display.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants, types and helpers for the MM:SS / score seven-segment
// display. Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned SEG_W        = 7;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned ONES_MAX     = 9;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned MIN_TENS_MAX = 5;
    // Any code above 9 renders as a dash in the decoder.
    localparam int unsigned DASH_CODE    = 10;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

    // Elapsed time as four BCD digits.
    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } bcd_time_t;

    // What the next multiplexed digit should show.
    typedef struct packed {
        logic [DIGIT_W-1:0] value;
        logic               blank;
        logic               dp;
    } digit_sel_t;

    // Value to active-low glyph; values 10-15 render as a dash.
    function automatic logic [SEG_W-1:0] digit_pattern(input logic [DIGIT_W-1:0] value);
        logic [SEG_W-1:0] pattern;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // One-cold anode enable for a digit index.
    function automatic logic [NUM_DIGITS-1:0] anode_decode(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder
// Combinational glyph decoder for one seven-segment digit.
//   value     : 4-bit digit value (10-15 shown as dash)
//   blank     : 1 = all segments off, overrides value
//   pattern_c : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic               blank,
    output logic [SEG_W-1:0]   pattern_c
);

    always_comb begin
        pattern_c = SEG_BLANK;
        if (!blank) begin
            pattern_c = digit_pattern(value);
        end
    end

endmodule

// File: rtl/seg_timer_display.sv
// -----------------------------------------------------------------------------
// seg_timer_display
// MM:SS elapsed-time counter with a 4-digit multiplexed seven-segment driver
// and an alternate two-player score view.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   secclk     : 1 Hz single-cycle enable, advances time when run=1
//   segclk     : digit-multiplex single-cycle enable
//   run        : time advances on secclk while high
//   clear      : forces time to 00:00, beats run/secclk
//   show_score : 1 = score view, 0 = timer view
//   score1/2   : player scores (10-15 shown as dash)
//   an         : active-low digit enables, an[0] = rightmost
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point (MM.SS separator on digit 2)
// -----------------------------------------------------------------------------
module seg_timer_display
    import seg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  secclk,
    input  logic                  segclk,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  show_score,
    input  logic [DIGIT_W-1:0]    score1,
    input  logic [DIGIT_W-1:0]    score2,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp
);

    bcd_time_t          time_q;
    bcd_time_t          time_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_next;
    digit_sel_t         sel;
    logic [SEG_W-1:0]   dec_pattern;

    // Next time value: clear first, otherwise a fully cascaded +1 second.
    always_comb begin
        time_d = time_q;
        if (clear) begin
            time_d = '0;
        end else if (secclk && run) begin
            if (time_q.sec_ones == DIGIT_W'(ONES_MAX)) begin
                time_d.sec_ones = '0;
                if (time_q.sec_tens == DIGIT_W'(SEC_TENS_MAX)) begin
                    time_d.sec_tens = '0;
                    if (time_q.min_ones == DIGIT_W'(ONES_MAX)) begin
                        time_d.min_ones = '0;
                        if (time_q.min_tens == DIGIT_W'(MIN_TENS_MAX)) begin
                            time_d.min_tens = '0;
                        end else begin
                            time_d.min_tens = time_q.min_tens + DIGIT_W'(1);
                        end
                    end else begin
                        time_d.min_ones = time_q.min_ones + DIGIT_W'(1);
                    end
                end else begin
                    time_d.sec_tens = time_q.sec_tens + DIGIT_W'(1);
                end
            end else begin
                time_d.sec_ones = time_q.sec_ones + DIGIT_W'(1);
            end
        end
    end

    // Time register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    // Digit index wraps naturally at 2 bits; reset to 3 so the first pulse lands on digit 0.
    assign idx_next = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= IDX_W'(NUM_DIGITS - 1);
        end else if (segclk) begin
            idx_q <= idx_next;
        end
    end

    // Content of the digit about to be selected, from the current time/score values.
    always_comb begin
        sel.value = '0;
        sel.blank = 1'b0;
        sel.dp    = 1'b1;
        if (show_score) begin
            case (idx_next)
                2'd3:    sel.value = score1;
                2'd2:    sel.value = DIGIT_W'(DASH_CODE);
                2'd1:    sel.value = DIGIT_W'(DASH_CODE);
                default: sel.value = score2;
            endcase
        end else begin
            case (idx_next)
                2'd3: begin
                    sel.value = time_q.min_tens;
                    sel.blank = (time_q.min_tens == '0);
                end
                2'd2: begin
                    sel.value = time_q.min_ones;
                    sel.dp    = 1'b0;
                end
                2'd1:    sel.value = time_q.sec_tens;
                default: sel.value = time_q.sec_ones;
            endcase
        end
    end

    seg_decoder u_decoder (
        .value     (sel.value),
        .blank     (sel.blank),
        .pattern_c (dec_pattern)
    );

    // Display outputs update only on a multiplex pulse and hold in between.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (segclk) begin
            an  <= anode_decode(idx_next);
            seg <= dec_pattern;
            dp  <= sel.dp;
        end
    end

endmodule

// File: tb/tb_seg_timer_display.sv
// -----------------------------------------------------------------------------
// tb_seg_timer_display
// Self-checking bench: time kept as a plain seconds count, digits derived
// arithmetically, display outputs predicted per multiplex pulse.
// -----------------------------------------------------------------------------
module tb_seg_timer_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       secclk = 1'b0;
    logic       segclk = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic       show_score = 1'b0;
    logic [3:0] score1 = 4'd0;
    logic [3:0] score2 = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_secs;
    int         m_idx;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    logic [6:0] glyph [0:9];

    seg_timer_display dut (
        .clk        (clk),
        .rst        (rst),
        .secclk     (secclk),
        .segclk     (segclk),
        .run        (run),
        .clear      (clear),
        .show_score (show_score),
        .score1     (score1),
        .score2     (score2),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(input int v);
        if (v > 9) return G_DASH;
        return glyph[v];
    endfunction

    function automatic int digit_value(input int secs, input int d);
        case (d)
            3:       return secs / 600;
            2:       return (secs / 60) % 10;
            1:       return (secs % 60) / 10;
            default: return secs % 10;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int d);
        if (show_score) begin
            if (d == 3) return glyph_of(int'(score1));
            if (d == 0) return glyph_of(int'(score2));
            return G_DASH;
        end
        if (d == 3 && m_secs < 600) return G_BLANK;
        return glyph_of(digit_value(m_secs, d));
    endfunction

    // One clock with the given pulses; model updated from pre-edge values.
    task automatic step(input logic p_sec, input logic p_seg, input logic p_rst);
        secclk = p_sec;
        segclk = p_seg;
        rst    = p_rst;
        @(posedge clk);
        if (!p_rst) begin
            m_secs = 0;
            m_idx  = 3;
            m_an   = 4'hF;
            m_seg  = G_BLANK;
            m_dp   = 1'b1;
        end else begin
            if (p_seg) begin
                m_idx = (m_idx + 1) % 4;
                m_an  = 4'hF ^ 4'(1 << m_idx);
                m_seg = model_seg(m_idx);
                m_dp  = (!show_score && m_idx == 2) ? 1'b0 : 1'b1;
            end
            if (clear) m_secs = 0;
            else if (p_sec && run) m_secs = (m_secs + 1) % 3600;
        end
        #1;
        secclk = 1'b0;
        segclk = 1'b0;
        rst    = 1'b1;
    endtask

    task automatic do_reset();
        run = 1'b0; clear = 1'b0; show_score = 1'b0;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b, expected 1111 7f 1", an, seg, dp);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: an=%b seg=%h dp=%b, expected 1111 7f 1", an, seg, dp);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [0:3];
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (an !== exp_an[k] || seg !== m_seg || dp !== m_dp) begin
                n_fail++;
                $display("FAIL scan_digit%0d: an=%b seg=%h dp=%b, expected %b %h %b",
                         k, an, seg, dp, exp_an[k], m_seg, m_dp);
            end
            if (k == 3) begin
                n_tests++;
                if (seg !== 7'h7F) begin
                    n_fail++;
                    $display("FAIL scan_blank_d3: seg=%h expected 7f", seg);
                end
            end
            if (k == 2) begin
                n_tests++;
                if (seg !== 7'h40 || dp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan_d2_zero: seg=%h dp=%b expected 40 0", seg, dp);
                end
            end
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            n_tests++;
            if (an !== exp_an[k] || seg !== m_seg) begin
                n_fail++;
                $display("FAIL scan_hold%0d: an=%b seg=%h expected %b %h", k, an, seg, exp_an[k], m_seg);
            end
        end
    endtask

    task automatic test_count_61();
        logic [6:0] lit [0:3];
        lit[0] = 7'h79; lit[1] = 7'h40; lit[2] = 7'h79; lit[3] = 7'h7F;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 61; i++) step(1'b1, 1'b0, 1'b1);
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || seg !== m_seg || an !== m_an || dp !== m_dp) begin
                n_fail++;
                $display("FAIL count61_d%0d: an=%b seg=%h dp=%b, expected %b %h %b",
                         m_idx, an, seg, dp, m_an, lit[m_idx], m_dp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0] lit [0:3];
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 3599; i++) step(1'b1, 1'b0, 1'b1);
        lit[0] = 7'h10; lit[1] = 7'h12; lit[2] = 7'h10; lit[3] = 7'h12;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || an !== m_an || dp !== m_dp) begin
                n_fail++;
                $display("FAIL at5959_d%0d: seg=%h an=%b dp=%b, expected %h %b %b",
                         m_idx, seg, an, dp, lit[m_idx], m_an, m_dp);
            end
        end
        step(1'b1, 1'b0, 1'b1);
        lit[0] = 7'h40; lit[1] = 7'h40; lit[2] = 7'h40; lit[3] = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || seg !== m_seg || dp !== m_dp) begin
                n_fail++;
                $display("FAIL wrap0000_d%0d: seg=%h dp=%b, expected %h %b", m_idx, seg, dp, lit[m_idx], m_dp);
            end
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        run = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        lit[0] = 7'h12; lit[1] = 7'h40; lit[2] = 7'h40; lit[3] = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || seg !== m_seg) begin
                n_fail++;
                $display("FAIL runoff_hold_d%0d: seg=%h expected %h", m_idx, seg, lit[m_idx]);
            end
        end
    endtask

    task automatic test_clear();
        logic [6:0] lit [0:3];
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 754; i++) step(1'b1, 1'b0, 1'b1);
        lit[0] = 7'h19; lit[1] = 7'h30; lit[2] = 7'h24; lit[3] = 7'h79;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx]) begin
                n_fail++;
                $display("FAIL at1234_d%0d: seg=%h expected %h", m_idx, seg, lit[m_idx]);
            end
        end
        clear = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        clear = 1'b0;
        lit[0] = 7'h40; lit[1] = 7'h40; lit[2] = 7'h40; lit[3] = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || seg !== m_seg) begin
                n_fail++;
                $display("FAIL clear_d%0d: seg=%h expected %h", m_idx, seg, lit[m_idx]);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_score();
        logic [6:0] lit [0:3];
        lit[0] = 7'h3F; lit[1] = 7'h3F; lit[2] = 7'h3F; lit[3] = 7'h78;
        show_score = 1'b1;
        score1 = 4'd7;
        score2 = 4'd12;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (seg !== lit[m_idx] || dp !== 1'b1 || an !== m_an) begin
                n_fail++;
                $display("FAIL score_d%0d: seg=%h dp=%b an=%b, expected %h 1 %b",
                         m_idx, seg, dp, an, lit[m_idx], m_an);
            end
        end
        show_score = 1'b0;
    endtask

    task automatic test_reset_midscan();
        do_reset();
        run = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_reset: an=%b seg=%h dp=%b, expected 1111 7f 1", an, seg, dp);
        end
        run = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (an !== 4'b1110 || seg !== 7'h40) begin
            n_fail++;
            $display("FAIL midscan_first: an=%b seg=%h, expected 1110 40", an, seg);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) show_score = ~show_score;
            clear  = ($urandom_range(0, 39) == 0);
            score1 = 4'($urandom_range(0, 15));
            score2 = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 59) != 0));
            n_tests++;
            if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: an=%b seg=%h dp=%b, expected %b %h %b",
                         i, an, seg, dp, m_an, m_seg, m_dp);
            end
        end
        clear = 1'b0;
        run = 1'b0;
        show_score = 1'b0;
    endtask

    initial begin
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;
        m_secs = 0; m_idx = 3; m_an = 4'hF; m_seg = G_BLANK; m_dp = 1'b1;
        @(negedge clk);
        test_reset();
        test_scan();
        test_count_61();
        test_wrap();
        test_clear();
        test_score();
        test_reset_midscan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
